// File: rtl/conv1_pkg.sv
// conv1_pkg: frame geometry and pixel type shared by the conv1 window buffer and conv1_calc.
package conv1_pkg;
    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K     = 5;
    localparam int PIX_W = 8;
    typedef logic signed [PIX_W-1:0] pixel_t;
endpackage

// File: rtl/conv1_line_shift.sv
// conv1_line_shift: enable-gated pixel delay line between two rows of window taps.
module conv1_line_shift
    import conv1_pkg::*;
#(
    parameter int DEPTH = IMG_W - 1,
    parameter int BITS  = PIX_W
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic signed [BITS-1:0] din,
    output logic signed [BITS-1:0] dout
);
    logic signed [BITS-1:0] sr [DEPTH];

    // Contents are don't-care after reset, so the delay line carries no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];
endmodule

// File: rtl/conv1_window_buf.sv
// conv1_window_buf: streaming 5x5 window generator feeding the conv1 MAC pipeline.
module conv1_window_buf
    import conv1_pkg::*;
#(
    parameter int WIDTH     = IMG_W,
    parameter int HEIGHT    = IMG_H,
    parameter int KSIZE     = K,
    parameter int DATA_BITS = PIX_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid_in,
    input  logic signed [DATA_BITS-1:0] data_in,
    output logic signed [DATA_BITS-1:0] data_out_0,
    output logic signed [DATA_BITS-1:0] data_out_1,
    output logic signed [DATA_BITS-1:0] data_out_2,
    output logic signed [DATA_BITS-1:0] data_out_3,
    output logic signed [DATA_BITS-1:0] data_out_4,
    output logic signed [DATA_BITS-1:0] data_out_5,
    output logic signed [DATA_BITS-1:0] data_out_6,
    output logic signed [DATA_BITS-1:0] data_out_7,
    output logic signed [DATA_BITS-1:0] data_out_8,
    output logic signed [DATA_BITS-1:0] data_out_9,
    output logic signed [DATA_BITS-1:0] data_out_10,
    output logic signed [DATA_BITS-1:0] data_out_11,
    output logic signed [DATA_BITS-1:0] data_out_12,
    output logic signed [DATA_BITS-1:0] data_out_13,
    output logic signed [DATA_BITS-1:0] data_out_14,
    output logic signed [DATA_BITS-1:0] data_out_15,
    output logic signed [DATA_BITS-1:0] data_out_16,
    output logic signed [DATA_BITS-1:0] data_out_17,
    output logic signed [DATA_BITS-1:0] data_out_18,
    output logic signed [DATA_BITS-1:0] data_out_19,
    output logic signed [DATA_BITS-1:0] data_out_20,
    output logic signed [DATA_BITS-1:0] data_out_21,
    output logic signed [DATA_BITS-1:0] data_out_22,
    output logic signed [DATA_BITS-1:0] data_out_23,
    output logic signed [DATA_BITS-1:0] data_out_24,
    output logic                        valid_out_buf,
    output logic                        frame_done
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KSIZE - 1);

    // tap[k][c] is chain entry sr[k*WIDTH + c]; row k=0 is the newest image row.
    logic signed [DATA_BITS-1:0] tap  [KSIZE][KSIZE];
    logic signed [DATA_BITS-1:0] head [KSIZE];
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    assign head[0] = data_in;

    // Each delay line plus the next row's head tap spans exactly one image row.
    for (genvar g = 0; g < KSIZE - 1; g++) begin : g_line
        conv1_line_shift #(.DEPTH(WIDTH - 1), .BITS(DATA_BITS)) u_line (
            .clk  (clk),
            .en   (valid_in),
            .din  (tap[g][0]),
            .dout (head[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < KSIZE; k++)
                for (int c = 0; c < KSIZE; c++) tap[k][c] <= '0;
            col           <= '0;
            row           <= '0;
            valid_out_buf <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            valid_out_buf <= valid_in && row >= ROW_MIN && col >= COL_MIN;
            frame_done    <= valid_in && row == ROW_LAST && col == COL_LAST;
            if (valid_in) begin
                for (int k = 0; k < KSIZE; k++) begin
                    tap[k][0] <= head[k];
                    for (int c = 1; c < KSIZE; c++) tap[k][c] <= tap[k][c-1];
                end
                col <= (col == COL_LAST) ? '0 : col + CW'(1);
                row <= (col != COL_LAST) ? row : (row == ROW_LAST) ? '0 : row + RW'(1);
            end
        end
    end

    assign data_out_0  = tap[4][4];
    assign data_out_1  = tap[4][3];
    assign data_out_2  = tap[4][2];
    assign data_out_3  = tap[4][1];
    assign data_out_4  = tap[4][0];
    assign data_out_5  = tap[3][4];
    assign data_out_6  = tap[3][3];
    assign data_out_7  = tap[3][2];
    assign data_out_8  = tap[3][1];
    assign data_out_9  = tap[3][0];
    assign data_out_10 = tap[2][4];
    assign data_out_11 = tap[2][3];
    assign data_out_12 = tap[2][2];
    assign data_out_13 = tap[2][1];
    assign data_out_14 = tap[2][0];
    assign data_out_15 = tap[1][4];
    assign data_out_16 = tap[1][3];
    assign data_out_17 = tap[1][2];
    assign data_out_18 = tap[1][1];
    assign data_out_19 = tap[1][0];
    assign data_out_20 = tap[0][4];
    assign data_out_21 = tap[0][3];
    assign data_out_22 = tap[0][2];
    assign data_out_23 = tap[0][1];
    assign data_out_24 = tap[0][0];
endmodule

// File: tb/tb_conv1_window_buf.sv
// tb_conv1_window_buf: random and patterned frames checked against an image-array window model.
module tb_conv1_window_buf;
    localparam int W = 28;
    localparam int H = 28;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid_in = 1'b0;
    logic signed [7:0] data_in = '0;
    logic signed [7:0] q [25];
    logic valid_out_buf, frame_done;

    logic [7:0] img [H][W];
    int nchk = 0, npass = 0, nvalid, ndone;

    conv1_window_buf dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .data_out_0(q[0]),   .data_out_1(q[1]),   .data_out_2(q[2]),   .data_out_3(q[3]),
        .data_out_4(q[4]),   .data_out_5(q[5]),   .data_out_6(q[6]),   .data_out_7(q[7]),
        .data_out_8(q[8]),   .data_out_9(q[9]),   .data_out_10(q[10]), .data_out_11(q[11]),
        .data_out_12(q[12]), .data_out_13(q[13]), .data_out_14(q[14]), .data_out_15(q[15]),
        .data_out_16(q[16]), .data_out_17(q[17]), .data_out_18(q[18]), .data_out_19(q[19]),
        .data_out_20(q[20]), .data_out_21(q[21]), .data_out_22(q[22]), .data_out_23(q[23]),
        .data_out_24(q[24]),
        .valid_out_buf(valid_out_buf), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [199:0] taps();
        logic [199:0] v = '0;
        for (int i = 0; i < 25; i++) v = {v[191:0], q[i]};
        return v;
    endfunction

    // Window whose bottom-right pixel is (r, c), row-major from the top-left.
    function automatic logic [199:0] win(input int r, input int c);
        logic [199:0] v = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) v = {v[191:0], img[r-4+i][c-4+j]};
        return v;
    endfunction

    task automatic step(input bit v, input int r, input int c);
        bit ev, ed;
        @(negedge clk);
        valid_in = v;
        data_in  = v ? img[r][c] : 8'($urandom);
        @(posedge clk);
        #1;
        ev = v && r >= 4 && c >= 4;
        ed = v && r == H - 1 && c == W - 1;
        check("valid", 200'(valid_out_buf), 200'(ev));
        check("done", 200'(frame_done), 200'(ed));
        if (valid_out_buf) nvalid++;
        if (frame_done) ndone++;
        if (ev) check("window", taps(), win(r, c));
    endtask

    // mode 0: (row*28+col) mod 128 pattern, 1: random. gap 0: none, 1: alternate, 2: random.
    task automatic frame(input int mode, input int gap, input int stop);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = mode == 0 ? 8'((r * W + c) % 128) : 8'($urandom);
        nvalid = 0;
        ndone  = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gap == 2 && $urandom_range(3) == 0) step(0, 0, 0);
                step(1, r, c);
                if (gap == 1) step(0, 0, 0);
                if (mode == 0 && r == 4 && c == 4) begin
                    check("first_d0", 200'(q[0]), 200'(0));
                    check("first_d4", 200'(q[4]), 200'(4));
                    check("first_d5", 200'(q[5]), 200'(28));
                    check("first_d20", 200'(q[20]), 200'(112));
                    check("first_d24", 200'(q[24]), 200'(116));
                end
                if (mode == 0 && r == 5 && c == 4) begin
                    check("row5_d0", 200'(q[0]), 200'(28));
                    check("row5_d24", 200'(q[24]), 200'(16));
                end
                if (stop > 0 && r * W + c + 1 == stop) return;
            end
        end
        check("nwindows", 200'(nvalid), 200'(576));
        check("ndone", 200'(ndone), 200'(1));
    endtask

    initial begin
        #12;
        check("rst_taps", taps(), '0);
        check("rst_valid", 200'(valid_out_buf), '0);
        check("rst_done", 200'(frame_done), '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        frame(0, 0, 0);
        frame(0, 1, 0);
        frame(1, 2, 0);
        frame(1, 0, 0);
        frame(1, 0, 0);
        frame(0, 0, 300);
        @(negedge clk);
        valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_taps", taps(), '0);
        check("midrst_valid", 200'(valid_out_buf), '0);
        check("midrst_done", 200'(frame_done), '0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(0, 0, 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
